// File: rtl/rf_access_ctrl_pkg.sv
// Shared definitions for the register-file access sequencer: FSM state
// encoding, default widths and the hard-wired zero register index.
package rf_access_ctrl_pkg;

    localparam int DATA_W   = 8;
    localparam int ADDR_B   = 3;
    localparam int CNT_W    = 8;
    localparam int ZERO_REG = 0;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        READ     = 3'd1,
        ISSUE    = 3'd2,
        WAIT_RES = 3'd3,
        WRITE    = 3'd4
    } state_e;

endpackage

// File: rtl/rf_access_ctrl_wb_counter.sv
// rf_wb_counter: wrapping count of completed writebacks.
// Synchronous active-low clear, single-cycle increment strobe.
module rf_wb_counter #(
    parameter int Cnt_W = 8
) (
    input  logic             clk_i,
    input  logic             clr_ni,
    input  logic             inc_i,
    output logic [Cnt_W-1:0] count_o
);

    logic [Cnt_W-1:0] count_q;
    logic [Cnt_W-1:0] count_d;

    // Next count: add one on the strobe, wrapping naturally at 2**Cnt_W.
    always_comb begin
        count_d = count_q;
        if (inc_i) begin
            count_d = count_q + Cnt_W'(1);
        end
    end

    // Count register with synchronous clear.
    always_ff @(posedge clk_i) begin
        if (!clr_ni) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/rf_access_ctrl.sv
// rf_access_ctrl: one request at a time -> two operand reads, hand-off to
// execute, optional single writeback. Owns all RF address/strobe generation.
// Build option: define ZERO_REG_EN to make register 0 read as zero and
// suppress writes to it.
module rf_access_ctrl
    import rf_access_ctrl_pkg::*;
#(
    parameter int Data_W = DATA_W,
    parameter int Addr_B = ADDR_B,
    parameter int Cnt_W  = CNT_W
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [Addr_B-1:0] req_rs1,
    input  logic [Addr_B-1:0] req_rs2,
    input  logic [Addr_B-1:0] req_rd,
    input  logic              req_wb,
    output logic [Addr_B-1:0] rf_read_addr1,
    output logic [Addr_B-1:0] rf_read_addr2,
    input  logic [Data_W-1:0] rf_read_data1,
    input  logic [Data_W-1:0] rf_read_data2,
    output logic              rf_write_enable,
    output logic [Addr_B-1:0] rf_write_addr,
    output logic [Data_W-1:0] rf_write_data,
    output logic              op_valid,
    input  logic              op_ready,
    output logic [Data_W-1:0] op_a,
    output logic [Data_W-1:0] op_b,
    input  logic              res_valid,
    output logic              res_ready,
    input  logic [Data_W-1:0] res_data,
    output logic              busy,
    output logic [Cnt_W-1:0]  wb_count
);

`ifdef ZERO_REG_EN
    localparam logic [Addr_B-1:0] ZERO_IDX = Addr_B'(ZERO_REG);
`endif

    state_e            state_q,   state_d;
    logic [Addr_B-1:0] rs1_q,     rs1_d;
    logic [Addr_B-1:0] rs2_q,     rs2_d;
    logic [Addr_B-1:0] rd_q,      rd_d;
    logic              wb_q,      wb_d;
    logic [Data_W-1:0] op_a_q,    op_a_d;
    logic [Data_W-1:0] op_b_q,    op_b_d;
    logic [Addr_B-1:0] wr_addr_q, wr_addr_d;
    logic [Data_W-1:0] wr_data_q, wr_data_d;

    // Next-state, latch updates and handshake/strobe outputs.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
        state_d         = state_q;
        rs1_d           = rs1_q;
        rs2_d           = rs2_q;
        rd_d            = rd_q;
        wb_d            = wb_q;
        op_a_d          = op_a_q;
        op_b_d          = op_b_q;
        wr_addr_d       = wr_addr_q;
        wr_data_d       = wr_data_q;
        req_ready       = 1'b0;
        op_valid        = 1'b0;
        res_ready       = 1'b0;
        rf_write_enable = 1'b0;

        case (state_q)
            IDLE: begin
                req_ready = reset;
                if (req_valid && reset) begin
                    rs1_d   = req_rs1;
                    rs2_d   = req_rs2;
                    rd_d    = req_rd;
                    wb_d    = req_wb;
                    state_d = READ;
                end
            end
            READ: begin
`ifdef ZERO_REG_EN
                op_a_d = (rs1_q == ZERO_IDX) ? '0 : rf_read_data1;
                op_b_d = (rs2_q == ZERO_IDX) ? '0 : rf_read_data2;
`else
                op_a_d = rf_read_data1;
                op_b_d = rf_read_data2;
`endif
                state_d = ISSUE;
            end
            ISSUE: begin
                op_valid = reset;
                if (op_ready) begin
                    state_d = wb_q ? WAIT_RES : IDLE;
                end
            end
            WAIT_RES: begin
                res_ready = reset;
                if (res_valid) begin
                    wr_data_d = res_data;
                    wr_addr_d = rd_q;
                    state_d   = WRITE;
                end
            end
            WRITE: begin
`ifdef ZERO_REG_EN
                rf_write_enable = reset && (wr_addr_q != ZERO_IDX);
`else
                rf_write_enable = reset;
`endif
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and latched request/data registers; reset drops any transaction.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q   <= IDLE;
            rs1_q     <= '0;
            rs2_q     <= '0;
            rd_q      <= '0;
            wb_q      <= 1'b0;
            op_a_q    <= '0;
            op_b_q    <= '0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state_q   <= state_d;
            rs1_q     <= rs1_d;
            rs2_q     <= rs2_d;
            rd_q      <= rd_d;
            wb_q      <= wb_d;
            op_a_q    <= op_a_d;
            op_b_q    <= op_b_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
        end
    end

    rf_wb_counter #(
        .Cnt_W (Cnt_W)
    ) u_wb_counter (
        .clk_i   (clock),
        .clr_ni  (reset),
        .inc_i   (rf_write_enable),
        .count_o (wb_count)
    );

    assign rf_read_addr1 = rs1_q;
    assign rf_read_addr2 = rs2_q;
    assign rf_write_addr = wr_addr_q;
    assign rf_write_data = wr_data_q;
    assign op_a          = op_a_q;
    assign op_b          = op_b_q;
    assign busy          = reset && (state_q != IDLE);

endmodule

// File: tb/tb_rf_access_ctrl.sv
// Directed self-checking bench for rf_access_ctrl with a behavioural
// 8x8 register file attached to the read/write ports.
module tb_rf_access_ctrl;

    logic       clock;
    logic       reset;
    logic       req_valid;
    logic       req_ready;
    logic [2:0] req_rs1, req_rs2, req_rd;
    logic       req_wb;
    logic [2:0] rf_read_addr1, rf_read_addr2;
    logic [7:0] rf_read_data1, rf_read_data2;
    logic       rf_write_enable;
    logic [2:0] rf_write_addr;
    logic [7:0] rf_write_data;
    logic       op_valid;
    logic       op_ready;
    logic [7:0] op_a, op_b;
    logic       res_valid;
    logic       res_ready;
    logic [7:0] res_data;
    logic       busy;
    logic [7:0] wb_count;

    logic [7:0] rf [8];

    int n_checks = 0;
    int n_passed = 0;

    rf_access_ctrl dut (
        .clock           (clock),
        .reset           (reset),
        .req_valid       (req_valid),
        .req_ready       (req_ready),
        .req_rs1         (req_rs1),
        .req_rs2         (req_rs2),
        .req_rd          (req_rd),
        .req_wb          (req_wb),
        .rf_read_addr1   (rf_read_addr1),
        .rf_read_addr2   (rf_read_addr2),
        .rf_read_data1   (rf_read_data1),
        .rf_read_data2   (rf_read_data2),
        .rf_write_enable (rf_write_enable),
        .rf_write_addr   (rf_write_addr),
        .rf_write_data   (rf_write_data),
        .op_valid        (op_valid),
        .op_ready        (op_ready),
        .op_a            (op_a),
        .op_b            (op_b),
        .res_valid       (res_valid),
        .res_ready       (res_ready),
        .res_data        (res_data),
        .busy            (busy),
        .wb_count        (wb_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Register file model: combinational reads, clocked write.
    assign rf_read_data1 = rf[rf_read_addr1];
    assign rf_read_data2 = rf[rf_read_addr2];
    always @(posedge clock) begin
        if (rf_write_enable) rf[rf_write_addr] <= rf_write_data;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        else n_passed++;
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Full transaction; checks are skipped when verbose is 0 (bulk runs).
    task automatic run_txn(input logic [2:0] rs1, input logic [2:0] rs2, input logic [2:0] rd,
                           input logic wb, input int op_wait, input int res_wait,
                           input logic [7:0] res, input logic [7:0] exp_a, input logic [7:0] exp_b,
                           input logic exp_we, input bit verbose);
        if (verbose) check("idle_req_ready", req_ready, 1);
        req_rs1 = rs1; req_rs2 = rs2; req_rd = rd; req_wb = wb; req_valid = 1'b1;
        step();                                   // now READ
        req_valid = 1'b0;
        if (verbose) begin
            check("read_busy", busy, 1);
            check("read_req_ready", req_ready, 0);
            check("read_addr1", rf_read_addr1, rs1);
            check("read_addr2", rf_read_addr2, rs2);
            check("read_op_valid", op_valid, 0);
        end
        step();                                   // now ISSUE
        if (verbose) begin
            check("issue_op_valid", op_valid, 1);
            check("issue_op_a", op_a, exp_a);
            check("issue_op_b", op_b, exp_b);
        end
        for (int i = 0; i < op_wait; i++) begin
            res_valid = 1'b1; res_data = 8'hEE;   // must be ignored outside WAIT_RES
            step();
            if (verbose) begin
                check("bp_op_valid", op_valid, 1);
                check("bp_op_a", op_a, exp_a);
                check("bp_op_b", op_b, exp_b);
                check("bp_res_ready", res_ready, 0);
                check("bp_req_ready", req_ready, 0);
            end
        end
        res_valid = 1'b0;
        op_ready  = 1'b1;
        step();
        op_ready  = 1'b0;
        if (!wb) begin
            if (verbose) begin
                check("nowb_busy", busy, 0);
                check("nowb_req_ready", req_ready, 1);
                check("nowb_we", rf_write_enable, 0);
            end
            return;
        end
        if (verbose) check("wait_res_ready", res_ready, 1);
        for (int i = 0; i < res_wait; i++) begin
            step();
            if (verbose) begin
                check("wait_res_ready_hold", res_ready, 1);
                check("wait_req_ready", req_ready, 0);
                check("wait_we", rf_write_enable, 0);
            end
        end
        res_valid = 1'b1; res_data = res;
        step();                                   // now WRITE
        res_valid = 1'b0;
        if (verbose) begin
            check("write_we", rf_write_enable, exp_we);
            check("write_addr", rf_write_addr, rd);
            check("write_data", rf_write_data, res);
            check("write_res_ready", res_ready, 0);
        end
        step();                                   // back in IDLE
        if (verbose) begin
            check("post_write_we", rf_write_enable, 0);
            check("post_write_busy", busy, 0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b0; req_valid = 1'b0; req_rs1 = '0; req_rs2 = '0; req_rd = '0; req_wb = 1'b0;
        op_ready = 1'b0; res_valid = 1'b0; res_data = '0;
        rf[0] = 8'hFF; rf[1] = 8'h12; rf[2] = 8'h34; rf[3] = 8'h00;
        rf[4] = 8'h5A; rf[5] = 8'hA5; rf[6] = 8'h00; rf[7] = 8'hC3;
        step(); step();

        // Reset state
        check("rst_req_ready", req_ready, 0);
        check("rst_busy", busy, 0);
        check("rst_wb_count", wb_count, 0);
        check("rst_op_a", op_a, 0);
        check("rst_write_addr", rf_write_addr, 0);
        reset = 1'b1;
        step();

        // Basic writeback: 0x12, 0x34 -> result 0x46 into r3
        run_txn(3'd1, 3'd2, 3'd3, 1'b1, 0, 0, 8'h46, 8'h12, 8'h34, 1'b1, 1);
        check("basic_wb_count", wb_count, 1);
        check("basic_rf3", rf[3], 8'h46);

        // No writeback
        run_txn(3'd4, 3'd5, 3'd6, 1'b0, 0, 0, 8'h00, 8'h5A, 8'hA5, 1'b0, 1);
        check("nowb_wb_count", wb_count, 1);
        check("nowb_rf6", rf[6], 8'h00);

        // Backpressure, same-register rs1=rs2=rd=3 (reads 0x46)
        run_txn(3'd3, 3'd3, 3'd3, 1'b1, 5, 4, 8'h77, 8'h46, 8'h46, 1'b1, 1);
        check("bp_wb_count", wb_count, 2);
        check("bp_rf3", rf[3], 8'h77);

        // Mid-operation reset while in WAIT_RES
        req_rs1 = 3'd1; req_rs2 = 3'd2; req_rd = 3'd7; req_wb = 1'b1; req_valid = 1'b1;
        step(); req_valid = 1'b0;
        step();
        op_ready = 1'b1; step(); op_ready = 1'b0;
        check("mid_res_ready", res_ready, 1);
        res_valid = 1'b1; res_data = 8'hBB;
        reset = 1'b0;
        step();
        res_valid = 1'b0;
        check("mid_busy", busy, 0);
        check("mid_req_ready", req_ready, 0);
        check("mid_res_ready_low", res_ready, 0);
        check("mid_op_a", op_a, 0);
        check("mid_op_b", op_b, 0);
        check("mid_addr1", rf_read_addr1, 0);
        check("mid_write_data", rf_write_data, 0);
        check("mid_we", rf_write_enable, 0);
        check("mid_wb_count", wb_count, 0);
        step();
        check("mid_rf7", rf[7], 8'hC3);
        reset = 1'b1;
        step();
        run_txn(3'd1, 3'd2, 3'd7, 1'b1, 0, 1, 8'h99, 8'h12, 8'h34, 1'b1, 1);
        check("post_rst_wb_count", wb_count, 1);
        check("post_rst_rf7", rf[7], 8'h99);

        // Counter wrap: 255 more writebacks -> 256 total -> 0
        for (int i = 0; i < 255; i++) begin
            run_txn(3'd1, 3'd2, 3'd6, 1'b1, 0, 0, 8'h01, 8'h12, 8'h34, 1'b1, 0);
        end
        check("wrap_wb_count", wb_count, 0);

        // Register 0 handling
`ifdef ZERO_REG_EN
        run_txn(3'd0, 3'd1, 3'd0, 1'b1, 0, 0, 8'h55, 8'h00, 8'h12, 1'b0, 1);
        check("zero_wb_count", wb_count, 0);
        check("zero_rf0", rf[0], 8'hFF);
`else
        run_txn(3'd0, 3'd1, 3'd0, 1'b1, 0, 0, 8'h55, 8'hFF, 8'h12, 1'b1, 1);
        check("zero_wb_count", wb_count, 1);
        check("zero_rf0", rf[0], 8'h55);
`endif

        $display("%0d/%0d checks passed", n_passed, n_checks);
        $finish;
    end

endmodule
